// File: rtl/nv_fifo_ctrl_32x256_pkg.sv
// Shared sizes and types for the 32x256 FIFO controller.
// Widths are fixed by the wrapped RAM macro.
package nv_fifo_ctrl_32x256_pkg;
    localparam int AW    = 5;
    localparam int DW    = 256;
    localparam int DEPTH = 32;
    localparam int CW    = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [DW-1:0] data_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
endpackage

// File: rtl/nv_fifo_ctrl_32x256_if.sv
// Producer/consumer handshake bundle of the 32x256 FIFO.
// master drives requests, slave is the FIFO.
interface nv_fifo_ctrl_32x256_if;
    import nv_fifo_ctrl_32x256_pkg::*;

    logic  wr_pvld;
    logic  wr_prdy;
    data_t wr_pd;
    logic  rd_pvld;
    logic  rd_prdy;
    data_t rd_pd;
    cnt_t  ram_cnt;

    modport master (
        output wr_pvld, wr_pd, rd_prdy,
        input  wr_prdy, rd_pvld, rd_pd, ram_cnt
    );

    modport slave (
        input  wr_pvld, wr_pd, rd_prdy,
        output wr_prdy, rd_pvld, rd_pd, ram_cnt
    );
endinterface

// File: rtl/nv_fifo_ctrl_32x256_ram.sv
// 32x256 two-port RAM: registered read address (re),
// then gated output register (ore).
module nv_ram_rwsp_32x256
    import nv_fifo_ctrl_32x256_pkg::*;
(
    input  logic        clk,
    input  logic [31:0] pwrbus_ram_pd,
    input  logic        re,
    input  logic        we,
    input  ptr_t        ra,
    input  ptr_t        wa,
    input  data_t       di,
    input  logic        ore,
    output data_t       dout
);
    data_t mem [DEPTH];
    ptr_t  ra_d;
    data_t dout_r;

    // Power-bus controls have no behavioural effect in this model.
    wire unused_pwrbus = ^pwrbus_ram_pd;

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= di;
        if (re) ra_d <= ra;
        if (ore) dout_r <= mem[ra_d];
    end

    assign dout = dout_r;
endmodule

// File: rtl/nv_fifo_ctrl_32x256.sv
// Valid/ready FIFO around the 32x256 RAM, hiding its
// two-stage read path behind a full-throughput interface.
module nv_fifo_ctrl_32x256
    import nv_fifo_ctrl_32x256_pkg::*;
(
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic [31:0] pwrbus_ram_pd,
    nv_fifo_ctrl_32x256_if.slave bus
);
    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    cnt_t  used;
    cnt_t  rd_pend;
    logic  s1_v;
    logic  s2_v;
    logic  wr_acc;
    logic  re;
    logic  ore;
    data_t ram_dout;

    assign bus.wr_prdy = (used != FULL_CNT);
    assign wr_acc  = bus.wr_pvld & bus.wr_prdy;

    // used still counts the entry sitting in S1, so its slot
    // stays reserved until the data is in the output register.
    assign rd_pend = used - cnt_t'(s1_v);
    assign ore     = s1_v & (~s2_v | bus.rd_prdy);
    assign re      = (rd_pend != '0) & (~s1_v | ore);

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ptr_t'(1);
            if (re) rd_ptr <= rd_ptr + ptr_t'(1);
            used <= used + cnt_t'(wr_acc) - cnt_t'(ore);
            if (re) s1_v <= 1'b1;
            else if (ore) s1_v <= 1'b0;
            if (ore) s2_v <= 1'b1;
            else if (bus.rd_prdy) s2_v <= 1'b0;
        end
    end

    nv_ram_rwsp_32x256 u_ram (
        .clk           (nvdla_core_clk),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .re            (re),
        .we            (wr_acc),
        .ra            (rd_ptr),
        .wa            (wr_ptr),
        .di            (bus.wr_pd),
        .ore           (ore),
        .dout          (ram_dout)
    );

    assign bus.rd_pvld = s2_v;
    assign bus.rd_pd   = ram_dout;
    assign bus.ram_cnt = used;
endmodule

// File: tb/tb_nv_fifo_ctrl_32x256.sv
// Directed bench for the 32x256 FIFO controller.
// Inputs change and outputs are sampled 1ns after each edge.
module tb_nv_fifo_ctrl_32x256;
    import nv_fifo_ctrl_32x256_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pwr = 32'h0;
    int nvec = 0;
    int nmis = 0;

    nv_fifo_ctrl_32x256_if bus ();

    nv_fifo_ctrl_32x256 dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .pwrbus_ram_pd  (pwr),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    function automatic data_t mk(input int i);
        logic [31:0] w;
        w = i;
        mk = {8{w ^ 32'hC0DE_0000}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input data_t obs,
                       input data_t exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.wr_pvld = 1'b0;
        bus.rd_prdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        int rx;
        int tx;
        int last;
        int lat;
        logic hold;
        data_t held;

        bus.wr_pvld = 1'b0;
        bus.wr_pd   = '0;
        bus.rd_prdy = 1'b0;
        #2;
        do_reset();

        chk("rst_wr_prdy", data_t'(bus.wr_prdy), 1);
        chk("rst_rd_pvld", data_t'(bus.rd_pvld), 0);
        chk("rst_ram_cnt", data_t'(bus.ram_cnt), 0);

        // single write, latency 3
        bus.rd_prdy = 1'b1;
        bus.wr_pvld = 1'b1;
        bus.wr_pd   = {32{8'hA5}};
        step();
        bus.wr_pvld = 1'b0;
        chk("one_t1_cnt", data_t'(bus.ram_cnt), 1);
        chk("one_t1_vld", data_t'(bus.rd_pvld), 0);
        step();
        chk("one_t2_cnt", data_t'(bus.ram_cnt), 1);
        chk("one_t2_vld", data_t'(bus.rd_pvld), 0);
        step();
        chk("one_t3_vld", data_t'(bus.rd_pvld), 1);
        chk("one_t3_pd", bus.rd_pd, {32{8'hA5}});
        chk("one_t3_cnt", data_t'(bus.ram_cnt), 0);
        step();
        chk("one_t4_vld", data_t'(bus.rd_pvld), 0);

        // fill with rd_prdy low
        do_reset();
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            bus.wr_pvld = 1'b1;
            bus.wr_pd   = mk(acc);
            if (!bus.wr_prdy) break;
            acc++;
            step();
        end
        bus.wr_pvld = 1'b0;
        chk("fill_accepts", data_t'(acc), 33);
        chk("fill_wr_prdy", data_t'(bus.wr_prdy), 0);
        chk("fill_ram_cnt", data_t'(bus.ram_cnt), 32);
        chk("fill_rd_pvld", data_t'(bus.rd_pvld), 1);
        chk("fill_rd_pd", bus.rd_pd, mk(0));

        // single-cycle pop from full
        bus.rd_prdy = 1'b1;
        chk("pop_same_prdy", data_t'(bus.wr_prdy), 0);
        step();
        bus.rd_prdy = 1'b0;
        chk("pop_next_prdy", data_t'(bus.wr_prdy), 1);
        chk("pop_next_cnt", data_t'(bus.ram_cnt), 31);
        chk("pop_next_pd", bus.rd_pd, mk(1));
        step();
        chk("pop_hold_cnt", data_t'(bus.ram_cnt), 31);
        chk("pop_hold_pd", bus.rd_pd, mk(1));
        chk("pop_hold_vld", data_t'(bus.rd_pvld), 1);

        // continuous stream 0..99
        do_reset();
        tx = 0;
        rx = 0;
        last = -1;
        bus.rd_prdy = 1'b1;
        for (int c = 0; c < 300 && rx < 100; c++) begin
            bus.wr_pvld = (tx < 100);
            bus.wr_pd   = mk(tx);
            if (bus.rd_pvld) begin
                chk("strm_pd", bus.rd_pd, mk(rx));
                if (rx == 99) last = c;
                rx++;
            end
            if (bus.wr_pvld && bus.wr_prdy) tx++;
            step();
        end
        bus.wr_pvld = 1'b0;
        chk("strm_count", data_t'(rx), 100);
        chk("strm_last_cyc", data_t'(last), 102);

        // random back-pressure
        do_reset();
        tx = 0;
        rx = 0;
        hold = 1'b0;
        held = '0;
        for (int c = 0; c < 3000 && rx < 200; c++) begin
            bus.wr_pvld = (tx < 200);
            bus.wr_pd   = mk(tx);
            bus.rd_prdy = 1'($urandom_range(0, 1));
            if (hold) begin
                chk("bp_hold_vld", data_t'(bus.rd_pvld), 1);
                chk("bp_hold_pd", bus.rd_pd, held);
            end
            if (bus.rd_pvld && bus.rd_prdy) begin
                chk("bp_pd", bus.rd_pd, mk(rx));
                rx++;
            end
            hold = bus.rd_pvld & ~bus.rd_prdy;
            held = bus.rd_pd;
            if (bus.wr_pvld && bus.wr_prdy) tx++;
            step();
        end
        bus.wr_pvld = 1'b0;
        bus.rd_prdy = 1'b0;
        chk("bp_count", data_t'(rx), 200);

        // reset with data in flight
        do_reset();
        for (int k = 0; k < 10; k++) begin
            bus.wr_pvld = 1'b1;
            bus.wr_pd   = mk(500 + k);
            step();
        end
        bus.wr_pvld = 1'b0;
        chk("mid_pre_cnt", data_t'(bus.ram_cnt), 9);
        chk("mid_pre_vld", data_t'(bus.rd_pvld), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_vld", data_t'(bus.rd_pvld), 0);
        chk("mid_rst_cnt", data_t'(bus.ram_cnt), 0);
        chk("mid_rst_prdy", data_t'(bus.wr_prdy), 1);
        bus.rd_prdy = 1'b1;
        bus.wr_pvld = 1'b1;
        bus.wr_pd   = mk(777);
        step();
        bus.wr_pvld = 1'b0;
        lat = 1;
        while (!bus.rd_pvld && lat < 12) begin
            step();
            lat++;
        end
        chk("mid_after_lat", data_t'(lat), 3);
        chk("mid_after_pd", bus.rd_pd, mk(777));
        step();
        chk("mid_after_empty", data_t'(bus.rd_pvld), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end
endmodule
